// File: rtl/i2s_encoder.sv
// i2s_encoder: single-clock Philips-format I2S transmitter.
// Derives SCK/WS/SD from clk_60MHz and serializes stereo sample pairs
// delivered through a one-entry valid/ready holding buffer.
//
// Ports
//   clk_60MHz   in   clock, all state updates on its rising edge
//   rst         in   synchronous active-high reset
//   enable      in   1 = run, 0 = idle (serial outputs held low)
//   l_data      in   left sample, DATAWIDTH bits, sent MSB first
//   r_data      in   right sample, DATAWIDTH bits, sent MSB first
//   data_valid  in   l_data/r_data pair is valid
//   data_ready  out  holding buffer empty; pair moves on valid & ready
//   sck         out  bit clock
//   ws          out  word select, 0 = left, 1 = right
//   sd          out  serial data
//   frame_start out  one-cycle pulse when the left MSB is driven
//   underrun    out  one-cycle pulse when a frame starts with no pair buffered
//
// state  | meaning
// S_IDLE | enable low: sck/ws/sd held 0, divider and bit position parked
// S_RUN  | enable high: divider running, one bit per falling SCK

module i2s_encoder #(
   parameter int DATAWIDTH = 24,
   parameter int SLOT_BITS = 32,
   parameter int CLK_DIV   = 20
) (
   input  logic                 clk_60MHz,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [DATAWIDTH-1:0] l_data,
   input  logic [DATAWIDTH-1:0] r_data,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic                 sck,
   output logic                 ws,
   output logic                 sd,
   output logic                 frame_start,
   output logic                 underrun
);

   localparam int FRAME_BITS = 2 * SLOT_BITS;
   localparam int DIV_W      = $clog2(CLK_DIV);
   localparam int P_W        = $clog2(FRAME_BITS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [P_W-1:0]   P_LAST   = P_W'(FRAME_BITS - 1);
   localparam logic [P_W-1:0]   WS_FIRST = P_W'(SLOT_BITS - 1);
   localparam logic [P_W-1:0]   WS_LAST  = P_W'(FRAME_BITS - 2);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                state_q;
   logic [DIV_W-1:0]      div_cnt_q;
   logic [P_W-1:0]        p_q;
   logic [P_W-1:0]        p_d;
   logic [FRAME_BITS-1:0] sr_q;
   logic [FRAME_BITS-1:0] load_d;
   logic [DATAWIDTH-1:0]  buf_l_q;
   logic [DATAWIDTH-1:0]  buf_r_q;
   logic                  buf_full_q;
   logic                  buf_full_d;
   logic                  sck_q;
   logic                  ws_q;
   logic                  sd_q;
   logic                  frame_start_q;
   logic                  underrun_q;
   logic                  data_ready_q;
   logic                  accept;
   logic                  fall_evt;
   logic                  load_evt;
   logic [SLOT_BITS-1:0]  slot_l;
   logic [SLOT_BITS-1:0]  slot_r;

   assign accept   = data_valid & data_ready_q;
   assign fall_evt = (state_q == S_RUN) && enable && (div_cnt_q == DIV_LAST) && sck_q;
   assign p_d      = (p_q == P_LAST) ? '0 : p_q + 1'b1;
   assign load_evt = fall_evt && (p_d == '0);

   // Sample left-justified in its slot, padding bits trail the LSB.
   assign slot_l = SLOT_BITS'(buf_l_q) << (SLOT_BITS - DATAWIDTH);
   assign slot_r = SLOT_BITS'(buf_r_q) << (SLOT_BITS - DATAWIDTH);
   assign load_d = buf_full_q ? {slot_l, slot_r} : '0;

   // A frame load sees the pre-accept buffer state, so an accept on the
   // same edge as an empty-buffer load still lands for the next frame.
   always_comb begin
      buf_full_d = buf_full_q;
      if (load_evt && buf_full_q) begin
         buf_full_d = 1'b0;
      end else if (accept) begin
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk_60MHz) begin
      if (rst) begin
         state_q       <= S_IDLE;
         div_cnt_q     <= '0;
         p_q           <= P_LAST;
         sr_q          <= '0;
         buf_l_q       <= '0;
         buf_r_q       <= '0;
         buf_full_q    <= 1'b0;
         data_ready_q  <= 1'b1;
         sck_q         <= 1'b0;
         ws_q          <= 1'b0;
         sd_q          <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         if (accept) begin
            buf_l_q <= l_data;
            buf_r_q <= r_data;
         end
         buf_full_q    <= buf_full_d;
         data_ready_q  <= ~buf_full_d;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;

         case (state_q)
            S_IDLE: begin
               sck_q     <= 1'b0;
               ws_q      <= 1'b0;
               sd_q      <= 1'b0;
               div_cnt_q <= '0;
               p_q       <= P_LAST;
               if (enable) begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (!enable) begin
                  state_q   <= S_IDLE;
                  sck_q     <= 1'b0;
                  ws_q      <= 1'b0;
                  sd_q      <= 1'b0;
                  div_cnt_q <= '0;
                  p_q       <= P_LAST;
                  sr_q      <= '0;
               end else if (div_cnt_q == DIV_LAST) begin
                  div_cnt_q <= '0;
                  sck_q     <= ~sck_q;
                  if (sck_q) begin
                     p_q  <= p_d;
                     ws_q <= (p_d >= WS_FIRST) && (p_d <= WS_LAST);
                     if (p_d == '0) begin
                        sr_q          <= load_d;
                        sd_q          <= load_d[FRAME_BITS-1];
                        frame_start_q <= 1'b1;
                        underrun_q    <= ~buf_full_q;
                     end else begin
                        // sr_q[MSB] is already on sd; the next bit sits below it.
                        sr_q <= sr_q << 1;
                        sd_q <= sr_q[FRAME_BITS-2];
                     end
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign data_ready  = data_ready_q;
   assign sck         = sck_q;
   assign ws          = ws_q;
   assign sd          = sd_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;

endmodule
